d_flipflop_using_sr: RTL and testbench
======================================

D_FLIPFLOP_USING_SR -- requirements
Module: d_flipflop_using_sr

Interface
REQ-001 SHALL have parameter WIDTH, default 1, number of independent D-flop bit lanes (legal range 1..64).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port D  input  WIDTH  data to be captured.
REQ-005 SHALL have port Q  output  WIDTH  registered data.
REQ-006 SHALL have port Qn  output  WIDTH  complement of Q (Qn == ~Q at all times outside X-propagation).

Function
REQ-007 SHALL implement each bit lane as a clocked SR flip-flop core driven by S = D[i], R = ~D[i]; no direct D-to-Q register shortcut.
REQ-008 SHALL implement the SR core truth table on rising clk: S=0,R=0 hold; S=1,R=0 set Q=1; S=0,R=1 clear Q=0; S=1,R=1 hold (defined, never produced by the D wrapper).
REQ-009 SHALL update Q[i] to the value of D[i] sampled at the rising clk edge; latency one edge; new value visible immediately after that edge.
REQ-010 SHALL keep Q stable between rising edges regardless of any number of D transitions (no transparency on either clk level).
REQ-011 SHALL ignore falling clk edges completely.
REQ-012 SHALL treat all bit lanes independently; one lane's D never affects another lane's Q.
REQ-013 SHALL drive Qn from the same state element as Q (not a separate register), so Q and Qn never disagree in any cycle.
REQ-014 SHALL produce no combinational path from D to Q or Qn.
REQ-015 SHALL, when D changes coincident with a rising clk edge, capture the pre-edge D value (standard flop setup semantics); benches SHALL NOT rely on that race.
REQ-016 SHALL propagate X on D[i] to Q[i] at the next edge in simulation (no silent X masking).

Reset
REQ-017 SHALL force Q = 0 and Qn = all ones immediately on rst assertion, without waiting for clk.
REQ-018 SHALL hold Q = 0, Qn = all ones for as long as rst is high, ignoring clk and D.
REQ-019 SHALL resume normal capture at the first rising clk edge strictly after rst deasserts; an edge coincident with deassertion leaves Q = 0.
REQ-020 SHALL give rst priority over simultaneous set/clear from the SR core in the same cycle.
REQ-021 SHALL NOT define a power-up value without reset; Q is X until first reset or first clk capture.

Verification
REQ-022 SHALL pass: rst=1 at t=0, clk toggling, D=1 -> Q=0, Qn=1 throughout reset; first rising edge after rst=0 with D=1 -> Q=1, Qn=0.
REQ-023 SHALL pass: 10-unit clk period (rises at 5,15,25,...), D set to 1/0/1 at 10/20/30 -> Q = 1 after edge 15, 0 after edge 25, 1 after edge 35; Q constant between edges.
REQ-024 SHALL pass: Q=1, D pulses 1->0->1 entirely between two rising edges -> Q stays 1, no glitch on Q or Qn.
REQ-025 SHALL pass: Q=1, rst asserted mid-high-phase of clk (not on an edge) -> Q drops to 0 within same timestep; deasserted, next edge with D=1 -> Q=1.
REQ-026 SHALL pass: WIDTH=4, D sequence 4'hA, 4'h5, 4'hF, 4'h0 on successive edges -> Q = A,5,F,0 one edge later each, Qn = 5,A,0,F.
REQ-027 SHALL pass: random D each cycle for 1000 cycles vs. reference model Q(n+1)=D(n) with Qn==~Q checked every edge -> zero mismatches.

Source files
------------

// File: rtl/d_flipflop_using_sr.sv
// D flip-flop built from clocked SR cores, one per bit lane.
// Async active-high reset clears every lane; Qn is always the complement of Q.
module sr_ff_core (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    output logic q
);

    logic q_next;

    // 00/11 hold, 10 set, 01 clear; written as logic so an X on s/r reaches q
    assign q_next = (s & ~r) | (~(s ^ r) & q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= q_next;
        end
    end

endmodule

module d_flipflop_using_sr #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn
);

    logic [WIDTH-1:0] state;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        sr_ff_core u_core (
            .clk (clk),
            .rst (rst),
            .s   (D[i]),
            .r   (~D[i]),
            .q   (state[i])
        );
    end

    // Both outputs come from the same state bits
    assign Q  = state;
    assign Qn = ~state;

endmodule

// File: tb/tb_d_flipflop_using_sr.sv
// Scoreboard bench for d_flipflop_using_sr at WIDTH=4.
// Driver queues the expected Q per capture edge; monitor checks after each rising edge.
module tb_d_flipflop_using_sr;

    logic       clk;
    logic       rst;
    logic [3:0] D;
    logic [3:0] Q;
    logic [3:0] Qn;

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_q[$];
    logic [3:0] last_exp;
    bit         have_last = 0;

    d_flipflop_using_sr #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .D   (D),
        .Q   (Q),
        .Qn  (Qn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s at t=%0t: got=%h expected=%h", name, $time, got, want);
        end
    endtask

    task automatic issue(input logic [3:0] v);
        @(negedge clk);
        D = v;
        exp_q.push_back(v);
    endtask

    // Monitor: one expected value per rising edge while out of reset
    always @(posedge clk) begin
        logic [3:0] e;
        #1;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("q_after_edge", Q, e);
            check("qn_after_edge", Qn, ~e);
            last_exp  = e;
            have_last = 1;
        end
    end

    // Q must not move between rising edges
    always @(negedge clk) begin
        if (have_last && !rst) begin
            check("q_hold_low_phase", Q, last_exp);
        end
    end

    always @(posedge rst) have_last = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        D   = 4'hF;
        #1;
        check("reset_q", Q, 4'h0);
        check("reset_qn", Qn, 4'hF);
        repeat (2) begin
            @(posedge clk);
            #2;
            check("reset_hold_q", Q, 4'h0);
            check("reset_hold_qn", Qn, 4'hF);
        end

        // Release reset; first edge after release captures D=F
        @(negedge clk);
        rst = 1'b0;
        D   = 4'hF;
        exp_q.push_back(4'hF);

        issue(4'h0);
        issue(4'hF);
        issue(4'hA);
        issue(4'h5);
        issue(4'hF);
        issue(4'h0);
        issue(4'hF);

        // D pulses low and back between edges; Q stays F
        @(negedge clk);
        exp_q.push_back(4'hF);
        D = 4'h0;
        #1;
        check("glitch_q", Q, 4'hF);
        check("glitch_qn", Qn, 4'h0);
        D = 4'hF;
        #1;
        check("glitch_q2", Q, 4'hF);

        issue(4'h1);
        issue(4'h2);
        issue(4'h4);
        issue(4'h8);
        issue(4'hF);

        // Reset in the high phase, away from any edge
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midphase_rst_q", Q, 4'h0);
        check("midphase_rst_qn", Qn, 4'hF);
        @(negedge clk);
        rst = 1'b0;
        D   = 4'hF;
        exp_q.push_back(4'hF);

        for (int i = 0; i < 1000; i++) begin
            issue(4'($urandom));
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected values left, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
